// File: rtl/perceptron_mem_seq.sv
// Self-sequencing memory controller for the perceptron learning datapath.
// One START runs sample write, delta write and a saturating weight update.
module perceptron_mem_seq #(
    parameter int N_IN    = 2,
    parameter int WW      = 4,
    parameter int DELTA_W = 2,
    parameter int DW      = 12,
    parameter int N_SLOT  = 2,
    parameter int AW      = 2,
    parameter int PW      = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        s,
    input  logic [N_IN-1:0]             x,
    input  logic                        z,
    input  logic [(N_IN+1)*DELTA_W-1:0] delta,
    input  logic [DW-1:0]               read_data1,
    input  logic [DW-1:0]               read_data2,
    output logic                        busy,
    output logic                        done,
    output logic                        write_en,
    output logic [AW-1:0]               write_addr,
    output logic [DW-1:0]               write_data,
    output logic [AW-1:0]               read_addr1,
    output logic [AW-1:0]               read_addr2,
    output logic [(N_IN+1)*WW-1:0]      weights,
    output logic [PW-1:0]               slot_ptr
);

    localparam int FW  = (N_IN + 1) * WW;
    localparam int DLW = (N_IN + 1) * DELTA_W;

    localparam logic [AW-1:0] ADDR_WEIGHT = AW'(0);
    localparam logic [AW-1:0] ADDR_DELTA  = AW'(1);
    localparam logic [AW-1:0] SLOT_BASE   = AW'(2);
    localparam logic [PW-1:0] SLOT_LAST   = PW'(N_SLOT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_SMP = 2'd1,
        WR_DLT = 2'd2,
        WR_W   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [DLW-1:0]   delta_r;
    logic [DLW-1:0]   delta_s;
    logic             busy_s;
    logic             done_s;
    logic             write_en_s;
    logic [AW-1:0]    write_addr_s;
    logic [DW-1:0]    write_data_s;
    logic [AW-1:0]    read_addr1_s;
    logic [AW-1:0]    read_addr2_s;
    logic [FW-1:0]    weights_s;
    logic [PW-1:0]    slot_ptr_s;
    logic [FW-1:0]    upd_s;
    logic             unused_s;

    // Sample readback on port 2 is addressed for the datapath but not consumed here.
    assign unused_s = ^{read_data2, read_data1};

    // Signed add of a sign-extended delta to one weight field, clamped to the field range.
    function automatic logic [WW-1:0] sat_add(input logic [WW-1:0] w, input logic [DELTA_W-1:0] d);
        logic [WW:0] sum;
        sum = {w[WW-1], w} + {{(WW + 1 - DELTA_W){d[DELTA_W-1]}}, d};
        case (sum[WW:WW-1])
            2'b01:   sat_add = {1'b0, {(WW - 1){1'b1}}};
            2'b10:   sat_add = {1'b1, {(WW - 1){1'b0}}};
            default: sat_add = sum[WW-1:0];
        endcase
    endfunction

    // Updated weight word, built straight from the memory read so it can be registered as the WR_W write data.
    always_comb begin
        upd_s = '0;
        for (int i = 0; i <= N_IN; i++) begin
            upd_s[i*WW +: WW] = sat_add(read_data1[i*WW +: WW], delta_r[i*DELTA_W +: DELTA_W]);
        end
    end

    // Next state and next registered output values, decoded from the state being entered.
    always_comb begin
        state_s      = state_r;
        delta_s      = delta_r;
        busy_s       = 1'b0;
        done_s       = 1'b0;
        write_en_s   = 1'b0;
        write_addr_s = write_addr;
        write_data_s = write_data;
        read_addr1_s = read_addr1;
        read_addr2_s = read_addr2;
        weights_s    = weights;
        slot_ptr_s   = slot_ptr;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s      = WR_SMP;
                    delta_s      = delta;
                    busy_s       = 1'b1;
                    write_en_s   = 1'b1;
                    write_addr_s = SLOT_BASE + AW'(slot_ptr);
                    write_data_s = DW'({s, x, z});
                    read_addr1_s = ADDR_WEIGHT;
                    read_addr2_s = SLOT_BASE + AW'(slot_ptr);
                end else begin
                    state_s = IDLE;
                end
            end
            WR_SMP: begin
                state_s      = WR_DLT;
                busy_s       = 1'b1;
                write_en_s   = 1'b1;
                write_addr_s = ADDR_DELTA;
                write_data_s = DW'(delta_r);
            end
            WR_DLT: begin
                state_s      = WR_W;
                busy_s       = 1'b1;
                write_en_s   = 1'b1;
                write_addr_s = ADDR_WEIGHT;
                write_data_s = DW'(upd_s);
            end
            WR_W: begin
                // Weight write lands on this edge, so the copy and ring pointer advance together.
                state_s   = IDLE;
                done_s    = 1'b1;
                weights_s = write_data[FW-1:0];
                if (slot_ptr == SLOT_LAST) begin
                    slot_ptr_s = '0;
                end else begin
                    slot_ptr_s = slot_ptr + PW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs and the delta latched at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delta_r    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            read_addr1 <= '0;
            read_addr2 <= '0;
            weights    <= '0;
            slot_ptr   <= '0;
        end else begin
            delta_r    <= delta_s;
            busy       <= busy_s;
            done       <= done_s;
            write_en   <= write_en_s;
            write_addr <= write_addr_s;
            write_data <= write_data_s;
            read_addr1 <= read_addr1_s;
            read_addr2 <= read_addr2_s;
            weights    <= weights_s;
            slot_ptr   <= slot_ptr_s;
        end
    end

endmodule

// File: tb/tb_perceptron_mem_seq.sv
// Directed bench for perceptron_mem_seq with a synchronous-read register-file model.
module tb_perceptron_mem_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        s;
    logic [1:0]  x;
    logic        z;
    logic [5:0]  delta;
    logic [11:0] read_data1;
    logic [11:0] read_data2;
    logic        busy;
    logic        done;
    logic        write_en;
    logic [1:0]  write_addr;
    logic [11:0] write_data;
    logic [1:0]  read_addr1;
    logic [1:0]  read_addr2;
    logic [11:0] weights;
    logic [0:0]  slot_ptr;

    logic [11:0] mem [4];
    logic        pl_en;
    logic [1:0]  pl_addr;
    logic [11:0] pl_data;

    int checks;
    int errors;

    perceptron_mem_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s          (s),
        .x          (x),
        .z          (z),
        .delta      (delta),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .busy       (busy),
        .done       (done),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .weights    (weights),
        .slot_ptr   (slot_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: one write port, two synchronous read ports, bench preload port.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (write_en) begin
            mem[write_addr] <= write_data;
        end
        read_data1 <= mem[read_addr1];
        read_data2 <= mem[read_addr2];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [1:0] a, input logic [11:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_we"},    32'(write_en),   32'd0);
        chk({tag, "_waddr"}, 32'(write_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(write_data), 32'd0);
        chk({tag, "_ra1"},   32'(read_addr1), 32'd0);
        chk({tag, "_ra2"},   32'(read_addr2), 32'd0);
        chk({tag, "_wts"},   32'(weights),    32'd0);
        chk({tag, "_slot"},  32'(slot_ptr),   32'd0);
    endtask

    initial begin
        logic [1:0]  ring_addr [3];
        logic [11:0] ring_w    [3];
        logic [0:0]  ring_slot [3];

        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        s       = 1'b0;
        x       = 2'b00;
        z       = 1'b0;
        delta   = 6'b000000;
        pl_en   = 1'b0;
        pl_addr = 2'd0;
        pl_data = 12'h000;

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic update; inputs scrambled right after acceptance
        preload(2'd0, 12'h123);
        s = 1'b1; x = 2'b11; z = 1'b0; delta = 6'b011011; start = 1'b1;
        tick();
        start = 1'b0; s = 1'b0; x = 2'b00; z = 1'b1; delta = 6'b111111;
        chk("basic_smp_we",    32'(write_en),   32'd1);
        chk("basic_smp_addr",  32'(write_addr), 32'd2);
        chk("basic_smp_data",  32'(write_data), 32'h00E);
        chk("basic_smp_busy",  32'(busy),       32'd1);
        chk("basic_smp_ra1",   32'(read_addr1), 32'd0);
        chk("basic_smp_ra2",   32'(read_addr2), 32'd2);
        chk("basic_smp_done",  32'(done),       32'd0);
        tick();
        chk("basic_dlt_we",    32'(write_en),   32'd1);
        chk("basic_dlt_addr",  32'(write_addr), 32'd1);
        chk("basic_dlt_data",  32'(write_data), 32'h01B);
        tick();
        chk("basic_w_we",      32'(write_en),   32'd1);
        chk("basic_w_addr",    32'(write_addr), 32'd0);
        chk("basic_w_data",    32'(write_data), 32'h202);
        chk("basic_w_busy",    32'(busy),       32'd1);
        tick();
        chk("basic_done",      32'(done),       32'd1);
        chk("basic_done_busy", 32'(busy),       32'd0);
        chk("basic_done_we",   32'(write_en),   32'd0);
        chk("basic_weights",   32'(weights),    32'h202);
        chk("basic_slot",      32'(slot_ptr),   32'd1);
        chk("basic_mem0",      32'(mem[0]),     32'h202);
        chk("basic_mem1",      32'(mem[1]),     32'h01B);
        chk("basic_mem2",      32'(mem[2]),     32'h00E);
        tick();
        chk("basic_done_pulse", 32'(done),      32'd0);

        // Saturation in both directions
        preload(2'd0, 12'h787);
        s = 1'b0; x = 2'b01; z = 1'b1; delta = 6'b111001; start = 1'b1;
        tick();
        start = 1'b0;
        chk("sat_smp_addr",  32'(write_addr), 32'd3);
        chk("sat_smp_data",  32'(write_data), 32'h003);
        chk("sat_smp_ra2",   32'(read_addr2), 32'd3);
        tick();
        chk("sat_dlt_data",  32'(write_data), 32'h039);
        tick();
        chk("sat_w_data",    32'(write_data), 32'h687);
        tick();
        chk("sat_done",      32'(done),       32'd1);
        chk("sat_weights",   32'(weights),    32'h687);
        chk("sat_slot",      32'(slot_ptr),   32'd0);

        // Ring wrap with START held high: one update per acceptance, back to back
        ring_addr[0] = 2'd2;   ring_addr[1] = 2'd3;   ring_addr[2] = 2'd2;
        ring_w[0]    = 12'h797; ring_w[1]   = 12'h7A7; ring_w[2]   = 12'h7B7;
        ring_slot[0] = 1'b1;   ring_slot[1] = 1'b0;   ring_slot[2] = 1'b1;
        s = 1'b1; x = 2'b01; z = 1'b1; delta = 6'b010101; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("ring%0d_smp_addr", k), 32'(write_addr), 32'(ring_addr[k]));
            chk($sformatf("ring%0d_smp_data", k), 32'(write_data), 32'h00B);
            chk($sformatf("ring%0d_smp_done", k), 32'(done),       32'd0);
            tick();
            chk($sformatf("ring%0d_dlt_addr", k), 32'(write_addr), 32'd1);
            tick();
            chk($sformatf("ring%0d_w_data", k),   32'(write_data), 32'(ring_w[k]));
            tick();
            chk($sformatf("ring%0d_done", k),     32'(done),       32'd1);
            chk($sformatf("ring%0d_busy", k),     32'(busy),       32'd0);
            chk($sformatf("ring%0d_slot", k),     32'(slot_ptr),   32'(ring_slot[k]));
            chk($sformatf("ring%0d_weights", k),  32'(weights),    32'(ring_w[k]));
            if (k == 2) begin
                start = 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("ring_idle%0d_done", k), 32'(done),     32'd0);
            chk($sformatf("ring_idle%0d_busy", k), 32'(busy),     32'd0);
            chk($sformatf("ring_idle%0d_we", k),   32'(write_en), 32'd0);
        end

        // Reset asserted mid-cycle during the delta write
        s = 1'b0; x = 2'b10; z = 1'b0; delta = 6'b000101; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_smp_addr", 32'(write_addr), 32'd3);
        tick();
        chk("rst_dlt_addr", 32'(write_addr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick();
        tick();
        chk("rst_mem0_held", 32'(mem[0]), 32'h7B7);
        rst_n = 1'b1;
        tick();
        chk("rst_rel_busy", 32'(busy),     32'd0);
        chk("rst_rel_we",   32'(write_en), 32'd0);
        tick();
        chk("rst_rel_we2",  32'(write_en), 32'd0);
        chk("rst_rel_mem0", 32'(mem[0]),   32'h7B7);

        // Normal operation resumes from slot 0 after the abort
        s = 1'b0; x = 2'b00; z = 1'b1; delta = 6'b000000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_smp_addr", 32'(write_addr), 32'd2);
        chk("post_smp_data", 32'(write_data), 32'h001);
        tick();
        tick();
        chk("post_w_data",   32'(write_data), 32'h7B7);
        tick();
        chk("post_done",     32'(done),       32'd1);
        chk("post_weights",  32'(weights),    32'h7B7);
        chk("post_slot",     32'(slot_ptr),   32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
